// File: rtl/fwd_pkg.sv
// Shared forwarding definitions: operand-mux select encodings and default widths.
// The pipeline datapath muxes import this package so that encodings stay in one place.
package fwd_pkg;

  localparam int REG_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

  // 2'b11 is reserved and is never produced by the forwarding unit.
  typedef enum logic [1:0] {
    SEL_DATA = 2'b00,
    SEL_EX   = 2'b01,
    SEL_MEM  = 2'b10
  } fwd_sel_e;

  function automatic logic is_sel(input logic [1:0] sel, input fwd_sel_e code);
    return sel == code;
  endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// Compare/priority logic for one EX-stage source operand. Purely combinational.
module fwd_operand_sel
  import fwd_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             ctrl_ex,
  input  logic             ctrl_mem,
  output logic [1:0]       sel
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ctrl_ex  && (ex_rd  == src);
  assign mem_hit = ctrl_mem && (mem_rd == src);

  // EX is checked first: it holds the most recent write to the register.
  always_comb begin
    sel = SEL_DATA;
    if (ex_hit) begin
      sel = SEL_EX;
    end else if (mem_hit) begin
      sel = SEL_MEM;
    end
  end

endmodule

// File: rtl/forwarding.sv
// Forwarding unit: two operand selectors plus saturating counters of cycles that
// used EX or MEM forwarding. Selects never depend on clk or rst.
module forwarding
  import fwd_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] A,
  input  logic [REG_W-1:0] B,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             ctrl_ex,
  input  logic             ctrl_mem,
  output logic [1:0]       A_sel,
  output logic [1:0]       B_sel,
  output logic [CNT_W-1:0] ex_fwd_cnt,
  output logic [CNT_W-1:0] mem_fwd_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fwd_operand_sel #(.REG_W(REG_W)) u_sel_a (
    .src      (A),
    .ex_rd    (ex_rd),
    .mem_rd   (mem_rd),
    .ctrl_ex  (ctrl_ex),
    .ctrl_mem (ctrl_mem),
    .sel      (A_sel)
  );

  fwd_operand_sel #(.REG_W(REG_W)) u_sel_b (
    .src      (B),
    .ex_rd    (ex_rd),
    .mem_rd   (mem_rd),
    .ctrl_ex  (ctrl_ex),
    .ctrl_mem (ctrl_mem),
    .sel      (B_sel)
  );

  logic             ex_used;
  logic             mem_used;
  logic [CNT_W-1:0] ex_fwd_cnt_d;
  logic [CNT_W-1:0] ex_fwd_cnt_q;
  logic [CNT_W-1:0] mem_fwd_cnt_d;
  logic [CNT_W-1:0] mem_fwd_cnt_q;

  // One increment per cycle even when both operands use the same source.
  assign ex_used  = is_sel(A_sel, SEL_EX)  || is_sel(B_sel, SEL_EX);
  assign mem_used = is_sel(A_sel, SEL_MEM) || is_sel(B_sel, SEL_MEM);

  always_comb begin
    ex_fwd_cnt_d  = ex_fwd_cnt_q;
    mem_fwd_cnt_d = mem_fwd_cnt_q;
    if (ex_used && (ex_fwd_cnt_q != CNT_MAX)) begin
      ex_fwd_cnt_d = ex_fwd_cnt_q + CNT_ONE;
    end
    if (mem_used && (mem_fwd_cnt_q != CNT_MAX)) begin
      mem_fwd_cnt_d = mem_fwd_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_fwd_cnt_q  <= '0;
      mem_fwd_cnt_q <= '0;
    end else begin
      ex_fwd_cnt_q  <= ex_fwd_cnt_d;
      mem_fwd_cnt_q <= mem_fwd_cnt_d;
    end
  end

  assign ex_fwd_cnt  = ex_fwd_cnt_q;
  assign mem_fwd_cnt = mem_fwd_cnt_q;

endmodule

// File: tb/tb_forwarding.sv
// Bench for the forwarding unit: directed scenarios plus randomized traffic against a
// reference model; a second instance with 4-bit counters exercises saturation.
`timescale 1ns/1ps
module tb_forwarding;

  localparam logic [1:0] S_DATA = 2'b00;
  localparam logic [1:0] S_EX   = 2'b01;
  localparam logic [1:0] S_MEM  = 2'b10;

  logic        clk;
  logic        rst;
  logic [3:0]  A, B, ex_rd, mem_rd;
  logic        ctrl_ex, ctrl_mem;
  logic [1:0]  A_sel, B_sel, A_sel_s, B_sel_s;
  logic [15:0] ex_fwd_cnt, mem_fwd_cnt;
  logic [3:0]  ex_fwd_cnt_s, mem_fwd_cnt_s;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  forwarding dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ex_rd(ex_rd), .mem_rd(mem_rd),
    .ctrl_ex(ctrl_ex), .ctrl_mem(ctrl_mem), .A_sel(A_sel), .B_sel(B_sel),
    .ex_fwd_cnt(ex_fwd_cnt), .mem_fwd_cnt(mem_fwd_cnt)
  );

  forwarding #(.REG_W(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .A(A), .B(B), .ex_rd(ex_rd), .mem_rd(mem_rd),
    .ctrl_ex(ctrl_ex), .ctrl_mem(ctrl_mem), .A_sel(A_sel_s), .B_sel(B_sel_s),
    .ex_fwd_cnt(ex_fwd_cnt_s), .mem_fwd_cnt(mem_fwd_cnt_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: producers listed newest first; the first enabled writer of src supplies it.
  function automatic logic [1:0] ref_sel(input int src, input int e_rd, input int m_rd,
                                         input bit ce, input bit cm);
    int         rd   [2];
    bit         we   [2];
    logic [1:0] code [2];
    rd   = '{e_rd, m_rd};
    we   = '{ce, cm};
    code = '{S_EX, S_MEM};
    for (int i = 0; i < 2; i++) begin
      if (we[i] && rd[i] == src) return code[i];
    end
    return S_DATA;
  endfunction

  task automatic drive(input int a, input int b, input int er, input int mr,
                       input bit ce, input bit cm);
    A = a[3:0]; B = b[3:0]; ex_rd = er[3:0]; mem_rd = mr[3:0];
    ctrl_ex = ce; ctrl_mem = cm;
  endtask

  task automatic check_sels(input string name, input logic [1:0] ea, input logic [1:0] eb);
    #1;
    n_cmp++;
    if (A_sel !== ea || A_sel_s !== ea) begin
      n_err++;
      $display("FAIL %s A_sel got %0b/%0b want %0b", name, A_sel, A_sel_s, ea);
    end
    n_cmp++;
    if (B_sel !== eb || B_sel_s !== eb) begin
      n_err++;
      $display("FAIL %s B_sel got %0b/%0b want %0b", name, B_sel, B_sel_s, eb);
    end
  endtask

  task automatic check_cnts(input string name, input int ee, input int em);
    n_cmp++;
    if (ex_fwd_cnt !== 16'(ee)) begin
      n_err++;
      $display("FAIL %s ex_fwd_cnt got %0d want %0d", name, ex_fwd_cnt, ee);
    end
    n_cmp++;
    if (mem_fwd_cnt !== 16'(em)) begin
      n_err++;
      $display("FAIL %s mem_fwd_cnt got %0d want %0d", name, mem_fwd_cnt, em);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(10, 5, 10, 5, 1, 1);
    #1;
    check_cnts("reset", 0, 0);
    check_sels("sel_during_reset", S_EX, S_MEM);
    @(posedge clk); #1;
    check_cnts("reset_hold", 0, 0);
  endtask

  task automatic test_disabled;
    drive(10, 5, 0, 0, 1, 0);
    check_sels("disabled_ex_only", S_DATA, S_DATA);
    drive(10, 5, 0, 0, 0, 1);
    check_sels("disabled_mem_only", S_DATA, S_DATA);
    drive(10, 5, 10, 5, 0, 0);
    check_sels("we_low_matching_rd", S_DATA, S_DATA);
    drive(0, 0, 0, 3, 1, 0);
    check_sels("reg0_forwardable", S_EX, S_EX);
  endtask

  task automatic test_mem_fwd;
    drive(10, 5, 6, 10, 0, 1);
    check_sels("mem_fwd", S_MEM, S_DATA);
    drive(10, 5, 10, 6, 0, 1);
    check_sels("mem_fwd_miss", S_DATA, S_DATA);
  endtask

  task automatic test_dual;
    drive(10, 5, 10, 5, 1, 1);
    check_sels("dual_fwd", S_EX, S_MEM);
    drive(10, 5, 10, 5, 1, 0);
    check_sels("dual_mem_off", S_EX, S_DATA);
  endtask

  task automatic test_conflict;
    drive(7, 7, 7, 7, 1, 1);
    check_sels("conflict_ex_wins", S_EX, S_EX);
    drive(7, 7, 7, 7, 0, 1);
    check_sels("conflict_ex_off", S_MEM, S_MEM);
  endtask

  task automatic test_counters;
    @(negedge clk);
    rst = 1'b1;
    drive(10, 5, 10, 5, 1, 1);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cnts("cnt_after_3", 3, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_cnts("cnt_async_clear", 0, 0);
    @(posedge clk); #1;
    check_cnts("cnt_hold_in_reset", 0, 0);
  endtask

  task automatic test_saturation;
    @(negedge clk);
    rst = 1'b1;
    drive(3, 9, 3, 12, 1, 0);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (ex_fwd_cnt_s !== 4'd15 || mem_fwd_cnt_s !== 4'd0) begin
      n_err++;
      $display("FAIL sat_20 ex/mem got %0d/%0d want 15/0", ex_fwd_cnt_s, mem_fwd_cnt_s);
    end
    check_cnts("wide_20", 20, 0);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (ex_fwd_cnt_s !== 4'd15) begin
      n_err++;
      $display("FAIL sat_hold ex got %0d want 15", ex_fwd_cnt_s);
    end
  endtask

  task automatic test_random;
    int ex_m, mem_m, ex_s, mem_s;
    int a, b, er, mr;
    bit ce, cm;
    logic [1:0] ea, eb;
    logic [15:0] want_ex, want_mem;
    ex_m = 0; mem_m = 0; ex_s = 0; mem_s = 0;
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 0) begin
        a = $urandom_range(0, 3); b = $urandom_range(0, 3);
        er = $urandom_range(0, 3); mr = $urandom_range(0, 3);
      end else begin
        a = $urandom_range(0, 15); b = $urandom_range(0, 15);
        er = $urandom_range(0, 15); mr = $urandom_range(0, 15);
      end
      ce = 1'($urandom_range(0, 1));
      cm = 1'($urandom_range(0, 1));
      drive(a, b, er, mr, ce, cm);
      ea = ref_sel(a, er, mr, ce, cm);
      eb = ref_sel(b, er, mr, ce, cm);
      check_sels("random_sel", ea, eb);
      if (ea == S_EX || eb == S_EX) ex_m++;
      if (ea == S_MEM || eb == S_MEM) mem_m++;
      ex_s  = (ex_m  > 15) ? 15 : ex_m;
      mem_s = (mem_m > 15) ? 15 : mem_m;
      exp_q.push_back(16'(ex_m));
      exp_q.push_back(16'(mem_m));
      @(posedge clk); #1;
      want_ex  = exp_q.pop_front();
      want_mem = exp_q.pop_front();
      n_cmp++;
      if (ex_fwd_cnt !== want_ex || mem_fwd_cnt !== want_mem) begin
        n_err++;
        $display("FAIL random_cnt ex/mem got %0d/%0d want %0d/%0d",
                 ex_fwd_cnt, mem_fwd_cnt, want_ex, want_mem);
      end
      n_cmp++;
      if (ex_fwd_cnt_s !== 4'(ex_s) || mem_fwd_cnt_s !== 4'(mem_s)) begin
        n_err++;
        $display("FAIL random_sat_cnt ex/mem got %0d/%0d want %0d/%0d",
                 ex_fwd_cnt_s, mem_fwd_cnt_s, ex_s, mem_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_disabled();
    test_mem_fwd();
    test_dual();
    test_conflict();
    test_counters();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
